// File: rtl/csr_file.sv
// csr_file: machine-mode CSR storage for the 5-stage core.
// Combinational ID-stage read port, WB-stage CSRRW/CSRRS/CSRRC commit,
// 64-bit cycle/instret counters, interrupt entry, MRET and a registered
// one-cycle PC redirect towards fetch.
module csr_file #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] id_csr_addr,
    output logic [31:0] id_csr_rdata,
    input  logic [1:0]  wb_csr_op,
    input  logic [11:0] wb_csr_addr,
    input  logic [31:0] wb_csr_src,
    input  logic        wb_retire,
    input  logic [31:0] wb_pc,
    input  logic        wb_mret,
    input  logic        irq_ext,
    input  logic        irq_timer,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MIP       = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;

    localparam logic [31:0] MTVEC_RST   = MTVEC_RESET & ~32'h3;
    localparam logic [31:0] CAUSE_EXT   = 32'h8000_000B;
    localparam logic [31:0] CAUSE_TIMER = 32'h8000_0007;

    typedef enum logic [1:0] {
        CSR_NONE = 2'b00,
        CSR_RW   = 2'b01,
        CSR_RS   = 2'b10,
        CSR_RC   = 2'b11
    } csr_op_e;

    // Architectural state
    logic        mie_q, mie_d;          // mstatus.MIE
    logic        mpie_q, mpie_d;        // mstatus.MPIE
    logic        mtie_q, mtie_d;        // mie.MTIE
    logic        meie_q, meie_d;        // mie.MEIE
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    // WB-stage decode
    csr_op_e     wb_op;
    logic        wr_en;
    logic [31:0] wr_old;
    logic [31:0] wr_val;
    logic        ext_fire;
    logic        tmr_fire;
    logic        trap_take;
    logic        mret_take;

    // Read view of the registered state; shared by the ID port and the WB
    // read-modify-write so both always see identical field masking.
    function automatic logic [31:0] csr_read(input logic [11:0] addr);
        logic [31:0] v;
        v = '0;
        case (addr)
            ADDR_MSTATUS: begin
                v[12:11] = 2'b11;
                v[7]     = mpie_q;
                v[3]     = mie_q;
            end
            ADDR_MIE: begin
                v[11] = meie_q;
                v[7]  = mtie_q;
            end
            ADDR_MTVEC:     v = mtvec_q;
            ADDR_MSCRATCH:  v = mscratch_q;
            ADDR_MEPC:      v = mepc_q;
            ADDR_MCAUSE:    v = mcause_q;
            ADDR_MIP: begin
                v[11] = irq_ext;
                v[7]  = irq_timer;
            end
            ADDR_MCYCLE:    v = mcycle_q[31:0];
            ADDR_MCYCLEH:   v = mcycle_q[63:32];
            ADDR_MINSTRET:  v = minstret_q[31:0];
            ADDR_MINSTRETH: v = minstret_q[63:32];
            default:        v = '0;
        endcase
        return v;
    endfunction

    // ID-stage read: current registered state only, no WB bypass
    always_comb begin
        id_csr_rdata = csr_read(id_csr_addr);
    end

    // WB-stage write value and trap/MRET decision on pre-write state
    always_comb begin
        wb_op  = csr_op_e'(wb_csr_op);
        wr_en  = wb_retire && (wb_op != CSR_NONE);
        wr_old = csr_read(wb_csr_addr);
        case (wb_op)
            CSR_RW:  wr_val = wb_csr_src;
            CSR_RS:  wr_val = wr_old | wb_csr_src;
            CSR_RC:  wr_val = wr_old & ~wb_csr_src;
            default: wr_val = wr_old;
        endcase
        ext_fire  = meie_q & irq_ext;
        tmr_fire  = mtie_q & irq_timer;
        trap_take = wb_retire & ~wb_mret & mie_q & (ext_fire | tmr_fire);
        mret_take = wb_retire & wb_mret;
    end

    // Next-state: counters, CSR write, then trap/MRET overrides on top
    always_comb begin
        mie_d            = mie_q;
        mpie_d           = mpie_q;
        mtie_d           = mtie_q;
        meie_d           = meie_q;
        mtvec_d          = mtvec_q;
        mscratch_d       = mscratch_q;
        mepc_d           = mepc_q;
        mcause_d         = mcause_q;
        mcycle_d         = mcycle_q + 64'd1;
        minstret_d       = minstret_q + {63'd0, wb_retire};
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;

        // A written counter half replaces that half's increment; the other
        // half holds its old value, so no carry crosses in that cycle.
        if (wr_en) begin
            case (wb_csr_addr)
                ADDR_MSTATUS: begin
                    mie_d  = wr_val[3];
                    mpie_d = wr_val[7];
                end
                ADDR_MIE: begin
                    mtie_d = wr_val[7];
                    meie_d = wr_val[11];
                end
                ADDR_MTVEC:     mtvec_d    = {wr_val[31:2], 2'b00};
                ADDR_MSCRATCH:  mscratch_d = wr_val;
                ADDR_MEPC:      mepc_d     = {wr_val[31:2], 2'b00};
                ADDR_MCAUSE:    mcause_d   = wr_val;
                ADDR_MCYCLE:    mcycle_d   = {mcycle_q[63:32], wr_val};
                ADDR_MCYCLEH:   mcycle_d   = {wr_val, mcycle_q[31:0]};
                ADDR_MINSTRET:  minstret_d = {minstret_q[63:32], wr_val};
                ADDR_MINSTRETH: minstret_d = {wr_val, minstret_q[31:0]};
                default: ;
            endcase
        end

        // Trap entry overrides fields the instruction may have just written;
        // the vector comes from mtvec including any write this cycle.
        if (trap_take) begin
            mepc_d           = (wb_pc + 32'd4) & ~32'h3;
            mcause_d         = ext_fire ? CAUSE_EXT : CAUSE_TIMER;
            mpie_d           = mie_q;
            mie_d            = 1'b0;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = mtvec_d;
        end else if (mret_take) begin
            mie_d            = mpie_q;
            mpie_d           = 1'b1;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = mepc_d;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mie_q            <= 1'b0;
            mpie_q           <= 1'b0;
            mtie_q           <= 1'b0;
            meie_q           <= 1'b0;
            mtvec_q          <= MTVEC_RST;
            mscratch_q       <= '0;
            mepc_q           <= '0;
            mcause_q         <= '0;
            mcycle_q         <= '0;
            minstret_q       <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            mie_q            <= mie_d;
            mpie_q           <= mpie_d;
            mtie_q           <= mtie_d;
            meie_q           <= meie_d;
            mtvec_q          <= mtvec_d;
            mscratch_q       <= mscratch_d;
            mepc_q           <= mepc_d;
            mcause_q         <= mcause_d;
            mcycle_q         <= mcycle_d;
            minstret_q       <= minstret_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: directed stimulus with a scoreboard for csr_file.
// Stimulus pushes expected read data and expected redirects into queues;
// a negedge monitor pops and compares whenever the DUT presents a read
// request or a redirect pulse.
module tb_csr_file;

    logic        clk;
    logic        rst_n;
    logic [11:0] id_csr_addr;
    logic [31:0] id_csr_rdata;
    logic [1:0]  wb_csr_op;
    logic [11:0] wb_csr_addr;
    logic [31:0] wb_csr_src;
    logic        wb_retire;
    logic [31:0] wb_pc;
    logic        wb_mret;
    logic        irq_ext;
    logic        irq_timer;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    csr_file #(.MTVEC_RESET(32'h0000_1003)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_csr_addr    (id_csr_addr),
        .id_csr_rdata   (id_csr_rdata),
        .wb_csr_op      (wb_csr_op),
        .wb_csr_addr    (wb_csr_addr),
        .wb_csr_src     (wb_csr_src),
        .wb_retire      (wb_retire),
        .wb_pc          (wb_pc),
        .wb_mret        (wb_mret),
        .irq_ext        (irq_ext),
        .irq_timer      (irq_timer),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard queues
    logic [31:0] rd_exp_q[$];
    string       rd_name_q[$];
    logic [31:0] rdr_pc_q[$];
    int          rdr_cyc_q[$];

    logic rd_req  = 1'b0;
    logic mon_en  = 1'b0;
    logic end_req = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    // Monitor: compares reads on request, every redirect pulse, and
    // leftover expectations at end of test
    always @(negedge clk) begin
        if (mon_en && rd_req) begin
            logic [31:0] e;
            string       n;
            e = rd_exp_q.pop_front();
            n = rd_name_q.pop_front();
            checks++;
            if (id_csr_rdata !== e) begin
                errors++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", n, id_csr_rdata, e);
            end
        end
        if (mon_en && redirect_valid !== 1'b0) begin
            checks++;
            if (rdr_pc_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_redirect: got valid=%b pc=0x%08h at cycle %0d expected no redirect",
                         redirect_valid, redirect_pc, cyc);
            end else begin
                logic [31:0] epc;
                int          ecyc;
                epc  = rdr_pc_q.pop_front();
                ecyc = rdr_cyc_q.pop_front();
                if (redirect_pc !== epc || cyc != ecyc) begin
                    errors++;
                    $display("FAIL redirect: got pc=0x%08h cycle %0d expected pc=0x%08h cycle %0d",
                             redirect_pc, cyc, epc, ecyc);
                end
            end
        end
        if (end_req) begin
            checks++;
            if (rdr_pc_q.size() != 0 || rd_exp_q.size() != 0) begin
                errors++;
                $display("FAIL missing_events: got %0d redirects/%0d reads outstanding expected 0/0",
                         rdr_pc_q.size(), rd_exp_q.size());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_csr_op   = 2'b00;
        wb_csr_addr = 12'h000;
        wb_csr_src  = 32'h0;
        wb_retire   = 1'b0;
        wb_mret     = 1'b0;
        wb_pc       = 32'h0;
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] e, input string n);
        id_csr_addr = a;
        rd_exp_q.push_back(e);
        rd_name_q.push_back(n);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
    endtask

    task automatic expect_redir(input logic [31:0] pc);
        rdr_pc_q.push_back(pc);
        rdr_cyc_q.push_back(cyc + 1);
    endtask

    task automatic retire(input logic [31:0] pc, input logic mret,
                          input logic [1:0] op, input logic [11:0] a, input logic [31:0] src);
        wb_retire   = 1'b1;
        wb_pc       = pc;
        wb_mret     = mret;
        wb_csr_op   = op;
        wb_csr_addr = a;
        wb_csr_src  = src;
        tick();
        idle();
    endtask

    task automatic csr_wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] src);
        retire(32'h0, 1'b0, op, a, src);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        irq_ext     = 1'b0;
        irq_timer   = 1'b0;
        id_csr_addr = 12'h000;
        idle();
        tick();
        mon_en = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset values
        rd(12'hB00, 32'h0, "mcycle_after_reset");
        rd(12'hB02, 32'h0, "minstret_after_reset");
        rd(12'hB00, 32'h2, "mcycle_counting");
        rd(12'h305, 32'h0000_1000, "mtvec_reset");
        rd(12'h300, 32'h0000_1800, "mstatus_reset");
        rd(12'h341, 32'h0, "mepc_reset");
        rd(12'h342, 32'h0, "mcause_reset");
        rd(12'h304, 32'h0, "mie_reset");

        // Read-modify-write ops on mscratch
        csr_wr(2'b01, 12'h340, 32'hA5A5_0000);
        rd(12'h340, 32'hA5A5_0000, "mscratch_rw");
        csr_wr(2'b10, 12'h340, 32'h0000_00FF);
        rd(12'h340, 32'hA5A5_00FF, "mscratch_rs");
        csr_wr(2'b11, 12'h340, 32'hA500_0000);
        rd(12'h340, 32'h00A5_00FF, "mscratch_rc");
        csr_wr(2'b01, 12'h123, 32'hFFFF_FFFF);
        rd(12'h123, 32'h0, "unmapped_read");

        // mip reflects the pins and ignores writes
        irq_timer = 1'b1;
        rd(12'h344, 32'h0000_0080, "mip_timer");
        irq_timer = 1'b0;
        irq_ext   = 1'b1;
        rd(12'h344, 32'h0000_0800, "mip_ext");
        irq_ext = 1'b0;
        csr_wr(2'b01, 12'h344, 32'hFFFF_FFFF);
        rd(12'h344, 32'h0, "mip_write_ignored");

        // Low address bits forced to zero
        csr_wr(2'b01, 12'h341, 32'h0000_1237);
        rd(12'h341, 32'h0000_1234, "mepc_align");
        csr_wr(2'b01, 12'h305, 32'h0000_0403);
        rd(12'h305, 32'h0000_0400, "mtvec_align");

        // Enable interrupts
        csr_wr(2'b01, 12'h304, 32'h0000_0880);
        rd(12'h304, 32'h0000_0880, "mie_enable");
        csr_wr(2'b10, 12'h300, 32'h0000_0008);
        rd(12'h300, 32'h0000_1808, "mstatus_mie_set");

        // Both interrupts pending: external wins
        irq_ext   = 1'b1;
        irq_timer = 1'b1;
        expect_redir(32'h0000_0400);
        retire(32'h0000_0200, 1'b0, 2'b00, 12'h000, 32'h0);
        rd(12'h341, 32'h0000_0204, "trap1_mepc");
        rd(12'h342, 32'h8000_000B, "trap1_mcause");
        rd(12'h300, 32'h0000_1880, "trap1_mstatus");
        // Masked while MIE=0: no redirect
        retire(32'h0000_0204, 1'b0, 2'b00, 12'h000, 32'h0);
        rd(12'h300, 32'h0000_1880, "masked_retire_mstatus");

        // MRET restores MIE
        expect_redir(32'h0000_0204);
        retire(32'h0000_0400, 1'b1, 2'b00, 12'h000, 32'h0);
        rd(12'h300, 32'h0000_1888, "mret1_mstatus");
        // MRET with MIE=1 and a pending interrupt: returns, does not trap
        expect_redir(32'h0000_0204);
        retire(32'h0000_0404, 1'b1, 2'b00, 12'h000, 32'h0);
        rd(12'h300, 32'h0000_1888, "mret2_mstatus");
        rd(12'h342, 32'h8000_000B, "mret2_mcause_kept");
        // Next ordinary retire traps
        expect_redir(32'h0000_0400);
        retire(32'h0000_0300, 1'b0, 2'b00, 12'h000, 32'h0);
        rd(12'h341, 32'h0000_0304, "trap2_mepc");
        rd(12'h300, 32'h0000_1880, "trap2_mstatus");
        expect_redir(32'h0000_0304);
        retire(32'h0000_0400, 1'b1, 2'b00, 12'h000, 32'h0);

        // Timer trap on an instruction that rewrites mtvec
        irq_ext = 1'b0;
        expect_redir(32'h0000_0800);
        retire(32'h0000_0400, 1'b0, 2'b01, 12'h305, 32'h0000_0803);
        rd(12'h342, 32'h8000_0007, "trap3_mcause_timer");
        rd(12'h341, 32'h0000_0404, "trap3_mepc");
        rd(12'h305, 32'h0000_0800, "trap3_mtvec");
        irq_timer = 1'b0;
        expect_redir(32'h0000_0404);
        retire(32'h0000_0800, 1'b1, 2'b00, 12'h000, 32'h0);
        rd(12'h300, 32'h0000_1888, "mret4_mstatus");

        // Counter wrap
        csr_wr(2'b01, 12'hB00, 32'hFFFF_FFFF);
        csr_wr(2'b01, 12'hB80, 32'hFFFF_FFFF);
        rd(12'hB80, 32'hFFFF_FFFF, "mcycleh_written");
        rd(12'hB00, 32'h0, "mcycle_wrapped");
        rd(12'hB80, 32'h0, "mcycleh_wrapped");

        // minstret write in a retire cycle: no +1
        csr_wr(2'b01, 12'hB02, 32'h0000_0100);
        rd(12'hB02, 32'h0000_0100, "minstret_written");
        retire(32'h0, 1'b0, 2'b00, 12'h000, 32'h0);
        rd(12'hB02, 32'h0000_0101, "minstret_incr");
        rd(12'hB82, 32'h0, "minstreth");

        // Reset asserted in a trap-decision cycle
        irq_ext     = 1'b1;
        rst_n       = 1'b0;
        wb_retire   = 1'b1;
        wb_pc       = 32'h0000_0500;
        tick();
        rst_n   = 1'b1;
        irq_ext = 1'b0;
        idle();
        rd(12'hB00, 32'h0, "mcycle_midreset");
        rd(12'h305, 32'h0000_1000, "mtvec_midreset");
        rd(12'h300, 32'h0000_1800, "mstatus_midreset");
        rd(12'h304, 32'h0, "mie_midreset");
        rd(12'h340, 32'h0, "mscratch_midreset");
        rd(12'h341, 32'h0, "mepc_midreset");
        rd(12'h342, 32'h0, "mcause_midreset");
        rd(12'hB02, 32'h0, "minstret_midreset");

        tick();
        tick();
        end_req = 1'b1;
        @(negedge clk);
        #1;
        end_req = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/csr_file.md
# csr_file

Machine-mode CSR storage for the 5-stage RISC-V core. Holds the M-mode CSR set, provides the combinational ID-stage read that the CSR forwarding mux overrides on EX/MEM/WB hazards, and commits CSRRW/CSRRS/CSRRC writes at WB. It also runs the cycle and instret counters, takes external and timer interrupts at WB retirement, executes MRET, and issues a registered PC redirect to fetch.

## Interface
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec; bits [1:0] are ignored.
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- id_csr_addr  in  12  CSR address read in ID.
- id_csr_rdata  out  32  combinational read of current registered state; 0 for unmapped addresses.
- wb_csr_op  in  2  00 none, 01 RW, 10 RS, 11 RC.
- wb_csr_addr  in  12  CSR address of the WB instruction.
- wb_csr_src  in  32  rs1 value or zero-extended uimm.
- wb_retire  in  1  a valid instruction retires this cycle.
- wb_pc  in  32  PC of the WB instruction.
- wb_mret  in  1  the WB instruction is MRET; qualified by wb_retire.
- irq_ext  in  1  level external interrupt.
- irq_timer  in  1  level timer interrupt.
- redirect_valid  out  1  registered one-cycle pulse: flush the pipeline and fetch from redirect_pc.
- redirect_pc  out  32  registered redirect target.

## Operation
- Address map:
  - mstatus 0x300: only MIE[3] and MPIE[7] are storage; MPP[12:11] reads 2'b11; all other bits read 0.
  - mie 0x304: only MTIE[7] and MEIE[11] are storage.
  - mtvec 0x305: direct mode; bits [1:0] are forced to 0.
  - mscratch 0x340: full 32-bit storage.
  - mepc 0x341: bits [1:0] are forced to 0.
  - mcause 0x342: full 32-bit storage.
  - mip 0x344: read-only; MTIP[7] = irq_timer, MEIP[11] = irq_ext.
  - mcycle 0xB00, mcycleh 0xB80: low and high halves of the 64-bit cycle counter.
  - minstret 0xB02, minstreth 0xB82: low and high halves of the 64-bit instret counter.
- Unmapped addresses: reads return 0; writes are ignored. Writes to mip are ignored.
- A write is performed only when wb_retire=1 and wb_csr_op≠00. With old = current value:
  - RW: new = src.
  - RS: new = old | src.
  - RC: new = old & ~src.
  - RS/RC with src=0 still counts as a write (harmless, since the value is unchanged).
- Counters:
  - mcycle increments by 1 every cycle.
  - minstret increments by 1 on each wb_retire.
  - Both are 64-bit and wrap from 2^64-1 to 0.
  - A CSR write to either half replaces that half's increment in the same cycle; the other half keeps its prior value (no carry in that cycle).
- Interrupt decision, evaluated on pre-write state:
  - take = wb_retire & ~wb_mret & MIE & ((MEIE & irq_ext) | (MTIE & irq_timer)).
  - External has priority: mcause = 0x8000_000B, otherwise 0x8000_0007.
- On take:
  - Retire semantics: the WB instruction's own CSR write is applied first.
  - Then, overriding any overlapping field: mepc ← wb_pc+4, mcause set as above, MPIE ← pre-write MIE, MIE ← 0.
  - Redirect target is mtvec as written this cycle, else the prior mtvec.
- On MRET (wb_retire & wb_mret): MIE ← MPIE, MPIE ← 1, redirect target = mepc. An interrupt is never taken in an MRET cycle.
- No WB→ID same-cycle bypass: a write is visible on id_csr_rdata from the next cycle. The forwarding stage covers the gap.

## Timing
- Reset values (rst_n=0 sampled at an edge):
  - 0: mstatus storage, mie, mscratch, mepc, mcause, all counters, redirect_valid, redirect_pc.
  - MTVEC_RESET & ~3: mtvec.
- Reset wins over every simultaneous event. A pending interrupt or MRET during reset is dropped, and no redirect follows reset release.
- Latency:
  - CSR write: 1 cycle to visibility.
  - Trap or MRET: redirect_valid=1 in the cycle after the deciding edge, for exactly one cycle.
- redirect_valid is not back-pressured. The decision may repeat on the next cycle only if wb_retire is high again, which the flush prevents.
- Level interrupts that stay high after a trap are masked, because MIE=0 until MRET.

## Test plan
- Reset release with MTVEC_RESET=32'h0000_1003:
  - Required: id_csr_rdata reads 0x1000 @0x305, 0x1800 @0x300 (MPP only), 0 @0x341.
  - Required: redirect_valid stays 0.
- CSR ops on mscratch:
  - Stimulus: RW 0xA5A5_0000, then RS 0x0000_00FF, then RC 0xA500_0000.
  - Required: reads 0xA5A5_0000, 0xA5A5_00FF, 0x00A5_00FF, each one cycle after its write.
  - Required: a read of 0x123 returns 0.
- Interrupt priority:
  - Stimulus: MIE=1, MEIE=MTIE=1, irq_ext=irq_timer=1, retire with wb_pc=0x200.
  - Required: mepc=0x204, mcause=0x8000_000B, MPIE=1, MIE=0.
  - Required: next cycle redirect_valid=1, redirect_pc=mtvec.
  - Follow-up: a second retire gives no redirect.
- MRET after the trap above:
  - Required: MIE=1, MPIE=1, one-cycle redirect to 0x204.
  - Stimulus: MRET with irq_ext still high.
  - Required: no trap in the MRET cycle; a trap on the next retire.
- Counter wrap and write:
  - Stimulus: RW mcycle=0xFFFF_FFFF, mcycleh=0xFFFF_FFFF.
  - Required: wrap to 0 two cycles later.
  - Stimulus: minstret write in a retire cycle.
  - Required: the written value holds, with no +1.
- Mid-operation reset:
  - Stimulus: assert rst_n=0 in the trap-decision cycle.
  - Required: no redirect_valid; all CSRs at reset values.
